// File: rtl/simple_dma_pkg.sv
// Shared types and constants for the simple DMA controller.
package simple_dma_pkg;

    // Controller FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DEV,
        ST_CAPTURE,
        ST_MEM_REQ,
        ST_MEM_RESP,
        ST_ACK,
        ST_GUARD,
        ST_DONE
    } state_t;

    // Transfer direction as presented on dma_rd_wr
    localparam logic DIR_READ  = 1'b1;   // memory -> device
    localparam logic DIR_WRITE = 1'b0;   // device -> memory

    // Byte-address step between consecutive 16-bit words
    localparam logic [15:0] ADDR_STEP = 16'd2;

    // Byte write enables for a full-word write and for a read
    localparam logic [1:0] WE_WORD = 2'b11;
    localparam logic [1:0] WE_NONE = 2'b00;

endpackage

// File: rtl/dma_xfer_cnt.sv
// Address and remaining-word counter for one block transfer.
module dma_xfer_cnt
    import simple_dma_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic        step,
    input  logic [15:0] start_addr,
    input  logic [15:0] num_words,
    output logic [14:0] word_addr,
    output logic        last
);

    logic [15:0] addr;
    logic [15:0] cnt;

    // Load on transfer start, advance by one word after each device strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: registers use <= so every flop samples pre-edge values, regardless of statement order.
            addr <= '0;
            cnt  <= '0;
        end else if (load) begin
            addr <= start_addr;
            cnt  <= num_words;
        end else if (step) begin
            addr <= addr + ADDR_STEP;   // modulo 2^16, 0xFFFE wraps to 0x0000
            cnt  <= cnt - 16'd1;
        end
    end

    assign word_addr = addr[15:1];
    assign last      = (cnt == 16'd1);

endmodule

// File: rtl/simple_dma_controller.sv
// Block-transfer DMA engine: moves 16-bit words between a DMA peripheral
// and system memory through the core's DMA master port.
module simple_dma_controller
    import simple_dma_pkg::*;
#(
    parameter logic PRIORITY = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dma_rqst,
    input  logic        dma_rd_wr,
    input  logic [15:0] dma_start_address,
    input  logic [15:0] dma_num_words,
    input  logic        dev_ack,
    input  logic [15:0] dev_out,
    output logic        dma_ack,
    output logic [15:0] dev_in,
    output logic        dma_end_flag,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_din,
    output logic        mem_en,
    output logic [1:0]  mem_we,
    output logic        mem_priority,
    input  logic [15:0] mem_dout,
    input  logic        mem_ready,
    input  logic        mem_resp,
    output logic        xfer_busy,
    output logic        xfer_error
);

    state_t      state;
    logic        rqst_q;     // dma_rqst delayed one cycle, for request/edge detection
    logic        dir;
    logic        abort_q;    // request dropped while an access is still in flight
    logic [15:0] rdata;
    logic        load;
    logic        step;
    logic [14:0] word_addr;
    logic        last;

    // A transfer starts once the request has been high for two samples
    assign load = (state == ST_IDLE) && rqst_q && dma_rqst;
    assign step = (state == ST_ACK);

    dma_xfer_cnt u_xfer_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .step       (step),
        .start_addr (dma_start_address),
        .num_words  (dma_num_words),
        .word_addr  (word_addr),
        .last       (last)
    );

    // Transfer FSM with registered device- and memory-side outputs.
    // mem_din doubles as the captured device write word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            rqst_q       <= 1'b0;
            dir          <= DIR_READ;
            abort_q      <= 1'b0;
            rdata        <= '0;
            dma_ack      <= 1'b0;
            dev_in       <= '0;
            dma_end_flag <= 1'b0;
            mem_addr     <= '0;
            mem_din      <= '0;
            mem_en       <= 1'b0;
            mem_we       <= WE_NONE;
            mem_priority <= PRIORITY;
            xfer_busy    <= 1'b0;
            xfer_error   <= 1'b0;
        end else begin
            rqst_q       <= dma_rqst;
            mem_priority <= PRIORITY;
            dma_ack      <= 1'b0;

            if (dma_rqst && !rqst_q)
                xfer_error <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (load) begin
                        dir     <= dma_rd_wr;
                        abort_q <= 1'b0;
                        if (dma_num_words == 16'd0) begin
                            state        <= ST_DONE;
                            dma_end_flag <= 1'b1;
                        end else begin
                            state     <= ST_WAIT_DEV;
                            xfer_busy <= 1'b1;
                        end
                    end
                end

                ST_WAIT_DEV: begin
                    if (!dma_rqst) begin
                        state     <= ST_IDLE;
                        xfer_busy <= 1'b0;
                    end else if (dev_ack) begin
                        if (dir == DIR_READ) begin
                            state    <= ST_MEM_REQ;
                            mem_en   <= 1'b1;
                            mem_we   <= WE_NONE;
                            mem_addr <= word_addr;
                        end else begin
                            state <= ST_CAPTURE;
                        end
                    end
                end

                ST_CAPTURE: begin
                    if (!dma_rqst) begin
                        state     <= ST_IDLE;
                        xfer_busy <= 1'b0;
                    end else begin
                        state    <= ST_MEM_REQ;
                        mem_din  <= dev_out;
                        mem_en   <= 1'b1;
                        mem_we   <= WE_WORD;
                        mem_addr <= word_addr;
                    end
                end

                ST_MEM_REQ: begin
                    // An accepted-pending access is never withdrawn
                    if (!dma_rqst)
                        abort_q <= 1'b1;
                    if (mem_ready) begin
                        mem_en <= 1'b0;
                        mem_we <= WE_NONE;
                        if (abort_q || !dma_rqst) begin
                            state     <= ST_IDLE;
                            xfer_busy <= 1'b0;
                        end else begin
                            state <= ST_MEM_RESP;
                        end
                    end
                end

                ST_MEM_RESP: begin
                    if (!dma_rqst) begin
                        state     <= ST_IDLE;
                        xfer_busy <= 1'b0;
                    end else if (mem_resp) begin
                        state        <= ST_DONE;
                        xfer_error   <= 1'b1;
                        dma_end_flag <= 1'b1;
                        xfer_busy    <= 1'b0;
                    end else begin
                        state   <= ST_ACK;
                        dma_ack <= 1'b1;
                        if (dir == DIR_READ) begin
                            rdata  <= mem_dout;
                            dev_in <= mem_dout;
                        end else begin
                            dev_in <= rdata;
                        end
                    end
                end

                ST_ACK: begin
                    if (!dma_rqst) begin
                        state     <= ST_IDLE;
                        xfer_busy <= 1'b0;
                    end else if (last) begin
                        state        <= ST_DONE;
                        dma_end_flag <= 1'b1;
                        xfer_busy    <= 1'b0;
                    end else begin
                        state <= ST_GUARD;
                    end
                end

                ST_GUARD: begin
                    if (!dma_rqst) begin
                        state     <= ST_IDLE;
                        xfer_busy <= 1'b0;
                    end else begin
                        state <= ST_WAIT_DEV;
                    end
                end

                ST_DONE: begin
                    if (!dma_rqst) begin
                        state        <= ST_IDLE;
                        dma_end_flag <= 1'b0;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    xfer_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simple_dma_controller.sv
// Self-checking bench for simple_dma_controller with a memory model and
// scoreboard queues for expected memory accesses and device strobes.
module tb_simple_dma_controller;
    import simple_dma_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        dma_rqst;
    logic        dma_rd_wr;
    logic [15:0] dma_start_address;
    logic [15:0] dma_num_words;
    logic        dev_ack;
    logic [15:0] dev_out;
    logic        dma_ack;
    logic [15:0] dev_in;
    logic        dma_end_flag;
    logic [14:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_en;
    logic [1:0]  mem_we;
    logic        mem_priority;
    logic [15:0] mem_dout;
    logic        mem_ready;
    logic        mem_resp;
    logic        xfer_busy;
    logic        xfer_error;

    simple_dma_controller #(.PRIORITY(1'b0)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .dma_rqst          (dma_rqst),
        .dma_rd_wr         (dma_rd_wr),
        .dma_start_address (dma_start_address),
        .dma_num_words     (dma_num_words),
        .dev_ack           (dev_ack),
        .dev_out           (dev_out),
        .dma_ack           (dma_ack),
        .dev_in            (dev_in),
        .dma_end_flag      (dma_end_flag),
        .mem_addr          (mem_addr),
        .mem_din           (mem_din),
        .mem_en            (mem_en),
        .mem_we            (mem_we),
        .mem_priority      (mem_priority),
        .mem_dout          (mem_dout),
        .mem_ready         (mem_ready),
        .mem_resp          (mem_resp),
        .xfer_busy         (xfer_busy),
        .xfer_error        (xfer_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] addr;
        logic [1:0]  we;
        logic [15:0] din;
    } acc_t;

    typedef struct {
        logic        chk;
        logic [15:0] data;
    } ack_t;

    acc_t acc_q[$];
    ack_t ack_q[$];

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Memory model: ready after wait_states cycles, data/response one cycle later
    logic [15:0] mem [0:32767];
    int          wait_states = 0;
    logic        err_next    = 1'b0;
    int          wait_cnt    = 0;
    logic        rdy_prev    = 1'b0;
    logic [14:0] lat_addr    = '0;
    logic [1:0]  lat_we      = '0;
    logic [15:0] lat_din     = '0;

    initial begin
        mem_ready = 1'b0;
        mem_dout  = '0;
        mem_resp  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            mem_resp = 1'b0;
            if (rdy_prev) begin
                if (lat_we == 2'b11)
                    mem[lat_addr] = lat_din;
                mem_dout = mem[lat_addr];
                mem_resp = err_next;
                err_next = 1'b0;
            end
            mem_ready = 1'b0;
            rdy_prev  = 1'b0;
            if (!mem_en) begin
                wait_cnt = 0;
            end else if (wait_cnt >= wait_states) begin
                mem_ready = 1'b1;
                rdy_prev  = 1'b1;
                lat_addr  = mem_addr;
                lat_we    = mem_we;
                lat_din   = mem_din;
                wait_cnt  = 0;
            end else begin
                wait_cnt++;
            end
        end
    end

    // Scoreboard: compare accepted accesses and device strobes against the queues
    always @(negedge clk) begin
        acc_t ea;
        ack_t ek;
        if (reset_n && mem_en && mem_ready) begin
            check("acc_expected", 32'(acc_q.size() > 0), 1);
            if (acc_q.size() > 0) begin
                ea = acc_q.pop_front();
                check("acc_addr", 32'(mem_addr), 32'(ea.addr));
                check("acc_we", 32'(mem_we), 32'(ea.we));
                if (ea.we == 2'b11)
                    check("acc_din", 32'(mem_din), 32'(ea.din));
            end
        end
        if (reset_n && dma_ack) begin
            check("ack_expected", 32'(ack_q.size() > 0), 1);
            if (ack_q.size() > 0) begin
                ek = ack_q.pop_front();
                if (ek.chk)
                    check("ack_dev_in", 32'(dev_in), 32'(ek.data));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bounded wait: 0 end_flag, 1 mem_en, 2 busy low, 3 dma_ack, 4 busy high
    task automatic wait_for(input int sel, input int budget, input string tag);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            case (sel)
                0:       hit = dma_end_flag;
                1:       hit = mem_en;
                2:       hit = !xfer_busy;
                3:       hit = dma_ack;
                default: hit = xfer_busy;
            endcase
        end
        check(tag, 32'(hit), 1);
    endtask

    task automatic push_acc(input logic [14:0] a, input logic [1:0] we, input logic [15:0] d);
        acc_t e;
        e.addr = a; e.we = we; e.din = d;
        acc_q.push_back(e);
    endtask

    task automatic push_ack(input logic chk, input logic [15:0] d);
        ack_t e;
        e.chk = chk; e.data = d;
        ack_q.push_back(e);
    endtask

    task automatic request(input logic rd, input logic [15:0] a, input logic [15:0] n);
        dma_rd_wr         = rd;
        dma_start_address = a;
        dma_num_words     = n;
        dma_rqst          = 1'b1;
    endtask

    // Drop the request from DONE; end flag falls one cycle after it is sampled low
    task automatic finish_xfer(input string tag);
        @(posedge clk);
        #1;
        dma_rqst = 1'b0;
        @(negedge clk);
        check({tag, "_end_hold"}, 32'(dma_end_flag), 1);
        @(negedge clk);
        check({tag, "_end_fall"}, 32'(dma_end_flag), 0);
        check({tag, "_acc_left"}, 32'(acc_q.size()), 0);
        check({tag, "_ack_left"}, 32'(ack_q.size()), 0);
        dev_ack = 1'b0;
        tick(2);
    endtask

    initial begin
        reset_n           = 1'b0;
        dma_rqst          = 1'b0;
        dma_rd_wr         = DIR_READ;
        dma_start_address = '0;
        dma_num_words     = '0;
        dev_ack           = 1'b0;
        dev_out           = '0;
        for (int i = 0; i < 32768; i++) mem[i] = '0;

        // Reset state
        @(negedge clk);
        check("rst_dma_ack", 32'(dma_ack), 0);
        check("rst_dev_in", 32'(dev_in), 0);
        check("rst_end_flag", 32'(dma_end_flag), 0);
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_din", 32'(mem_din), 0);
        check("rst_busy", 32'(xfer_busy), 0);
        check("rst_error", 32'(xfer_error), 0);
        check("rst_priority", 32'(mem_priority), 0);
        tick(2);
        reset_n = 1'b1;
        tick(2);

        // Read, atomic device
        mem[15'h100] = 16'h1111;
        mem[15'h101] = 16'h2222;
        mem[15'h102] = 16'h3333;
        push_acc(15'h100, 2'b00, '0);
        push_acc(15'h101, 2'b00, '0);
        push_acc(15'h102, 2'b00, '0);
        push_ack(1'b1, 16'h1111);
        push_ack(1'b1, 16'h2222);
        push_ack(1'b1, 16'h3333);
        dev_ack = 1'b1;
        request(DIR_READ, 16'h0200, 16'd3);
        @(negedge clk);
        @(negedge clk);
        check("t1_busy_edge_n", 32'(xfer_busy), 0);
        @(negedge clk);
        check("t1_busy_edge_n1", 32'(xfer_busy), 1);
        check("t1_en_edge_n1", 32'(mem_en), 0);
        @(negedge clk);
        check("t1_en_edge_n2", 32'(mem_en), 1);
        wait_for(0, 40, "t1_end");
        check("t1_busy_done", 32'(xfer_busy), 0);
        finish_xfer("t1");

        // Write, non-atomic device pulsing dev_ack
        push_acc(15'h180, 2'b11, 16'hA5A5);
        push_acc(15'h181, 2'b11, 16'h5A5A);
        push_ack(1'b0, '0);
        push_ack(1'b0, '0);
        dev_ack = 1'b0;
        dev_out = 16'h0000;
        request(DIR_WRITE, 16'h0300, 16'd2);
        wait_for(4, 10, "t2_busy");
        tick(1);
        dev_ack = 1'b1;
        tick(1);
        dev_ack = 1'b0;
        dev_out = 16'hA5A5;
        wait_for(3, 20, "t2_ack1");
        repeat (5) begin
            @(negedge clk);
            check("t2_stall_en", 32'(mem_en), 0);
        end
        check("t2_stall_busy", 32'(xfer_busy), 1);
        tick(1);
        dev_ack = 1'b1;
        tick(1);
        dev_ack = 1'b0;
        dev_out = 16'h5A5A;
        wait_for(0, 20, "t2_end");
        check("t2_mem0", 32'(mem[15'h180]), 32'h0000A5A5);
        check("t2_mem1", 32'(mem[15'h181]), 32'h00005A5A);
        finish_xfer("t2");

        // Memory wait states: request held stable
        wait_states  = 4;
        mem[15'h200] = 16'hBEEF;
        push_acc(15'h200, 2'b00, '0);
        push_ack(1'b1, 16'hBEEF);
        dev_ack = 1'b1;
        request(DIR_READ, 16'h0400, 16'd1);
        wait_for(1, 10, "t3_en");
        repeat (4) begin
            @(negedge clk);
            check("t3_hold_en", 32'(mem_en), 1);
            check("t3_hold_addr", 32'(mem_addr), 32'h200);
        end
        wait_for(0, 20, "t3_end");
        wait_states = 0;
        finish_xfer("t3");

        // Zero word count: straight to DONE, no access
        dev_ack = 1'b1;
        request(DIR_READ, 16'h0800, 16'd0);
        @(negedge clk);
        @(negedge clk);
        check("t3z_end_edge_n", 32'(dma_end_flag), 0);
        @(negedge clk);
        check("t3z_end_edge_n1", 32'(dma_end_flag), 1);
        check("t3z_mem_en", 32'(mem_en), 0);
        check("t3z_busy", 32'(xfer_busy), 0);
        finish_xfer("t3z");

        // Address wrap 0xFFFE -> 0x0000
        mem[15'h7FFF] = 16'h7777;
        mem[15'h0000] = 16'h0F0F;
        push_acc(15'h7FFF, 2'b00, '0);
        push_acc(15'h0000, 2'b00, '0);
        push_ack(1'b1, 16'h7777);
        push_ack(1'b1, 16'h0F0F);
        dev_ack = 1'b1;
        request(DIR_READ, 16'hFFFE, 16'd2);
        wait_for(0, 40, "t4_end");
        check("t4_no_error", 32'(xfer_error), 0);
        finish_xfer("t4");

        // Bus error on the first word: no strobe, sticky error, DONE
        mem[15'h008] = 16'h1234;
        push_acc(15'h008, 2'b00, '0);
        err_next = 1'b1;
        dev_ack  = 1'b1;
        request(DIR_READ, 16'h0010, 16'd2);
        wait_for(0, 30, "t4e_end");
        check("t4e_error", 32'(xfer_error), 1);
        check("t4e_busy", 32'(xfer_busy), 0);
        finish_xfer("t4e");
        check("t4e_error_sticky", 32'(xfer_error), 1);

        // Abort during a stalled access; new request clears the error flag
        wait_states = 6;
        push_acc(15'h280, 2'b00, '0);
        dev_ack = 1'b1;
        request(DIR_READ, 16'h0500, 16'd2);
        @(negedge clk);
        @(negedge clk);
        check("t5_error_clear", 32'(xfer_error), 0);
        wait_for(1, 10, "t5_en");
        tick(1);
        dma_rqst = 1'b0;
        @(negedge clk);
        check("t5_en_kept", 32'(mem_en), 1);
        wait_for(2, 20, "t5_idle");
        check("t5_acc_left", 32'(acc_q.size()), 0);
        repeat (8) @(negedge clk);
        check("t5_no_end", 32'(dma_end_flag), 0);
        check("t5_en_off", 32'(mem_en), 0);
        wait_states = 0;
        dev_ack = 1'b0;
        tick(1);

        // Asynchronous reset mid-transfer
        wait_states = 10;
        dev_ack     = 1'b1;
        request(DIR_READ, 16'h0600, 16'd3);
        wait_for(1, 10, "t6_en");
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_mem_en", 32'(mem_en), 0);
        check("t6_busy", 32'(xfer_busy), 0);
        check("t6_mem_addr", 32'(mem_addr), 0);
        check("t6_mem_din", 32'(mem_din), 0);
        check("t6_dev_in", 32'(dev_in), 0);
        check("t6_mem_we", 32'(mem_we), 0);
        check("t6_end_flag", 32'(dma_end_flag), 0);
        dma_rqst = 1'b0;
        dev_ack  = 1'b0;
        tick(2);
        reset_n     = 1'b1;
        wait_states = 0;
        tick(3);
        check("t6_idle_busy", 32'(xfer_busy), 0);
        check("t6_idle_en", 32'(mem_en), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop in case the stimulus sequence itself stalls
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
